// File: rtl/ctc_multi_pkg.sv
// rtl/ctc_multi_pkg.sv - register map and bit positions shared by the ctc_multi blocks
`timescale 1ns/1ps
package ctc_multi_pkg;
    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_RELOAD = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_IRQ_EN  = 3;

    localparam int STAT_DONE    = 0;
    localparam int STAT_OVERRUN = 1;
endpackage

// File: rtl/ctc_multi_if.sv
// rtl/ctc_multi_if.sv - Minisys 16-bit IO bus slice seen by the timer block
`timescale 1ns/1ps
interface ctc_multi_if;
    logic        cs;
    logic        iow;
    logic        ior;
    logic [3:0]  addr;
    logic [15:0] iowrite_data;
    logic [15:0] ioread_data;

    modport master (output cs, iow, ior, addr, iowrite_data, input ioread_data);
    modport slave  (input cs, iow, ior, addr, iowrite_data, output ioread_data);
endinterface

// File: rtl/ctc_multi_channel.sv
// rtl/ctc_multi_channel.sv - one down-counter channel (ctc_channel) with its registers
// CTC_PULSE_SYNC_EN adds a 2-flop synchroniser ahead of the pulse_in edge detector.
`timescale 1ns/1ps
module ctc_channel
    import ctc_multi_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic        iow,
    input  logic        ior,
    input  reg_e        reg_idx,
    input  logic [15:0] wdata,
    input  logic        pulse_in,
    output logic [15:0] rdata,
    output logic        pulse_out,
    output logic        irq
);
    logic             en, mode, oneshot, irq_en;
    logic [WIDTH-1:0] reload, count;
    logic             done, overrun;
    logic             pulse_q, pulse_edge;
    logic             wr_ctrl, wr_reload, rd_status, tick, terminal;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;

`ifdef CTC_PULSE_SYNC_EN
    logic sync1, sync2;
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1   <= pulse_in;
            sync2   <= sync1;
            pulse_q <= sync2;
        end
    end
    assign pulse_edge = sync2 & ~pulse_q;
`else
    always_ff @(posedge clock) begin
        if (!reset) pulse_q <= 1'b0;
        else        pulse_q <= pulse_in;
    end
    assign pulse_edge = pulse_in & ~pulse_q;
`endif

    assign wr_ctrl   = sel & iow & (reg_idx == REG_CTRL);
    assign wr_reload = sel & iow & (reg_idx == REG_RELOAD);
    assign rd_status = sel & ior & (reg_idx == REG_STATUS);
    // A CTRL write that clears en freezes COUNT on that same edge.
    assign tick      = en & ~(wr_ctrl & ~wdata[CTRL_EN]) & (mode ? pulse_edge : 1'b1);
    assign terminal  = tick & (count == WIDTH'(1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            en        <= 1'b0;
            mode      <= 1'b0;
            oneshot   <= 1'b0;
            irq_en    <= 1'b0;
            reload    <= '0;
            count     <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            pulse_out <= terminal;
            if (wr_reload) reload <= wdata[WIDTH-1:0];
            if (wr_ctrl) begin
                en      <= wdata[CTRL_EN];
                mode    <= wdata[CTRL_MODE];
                oneshot <= wdata[CTRL_ONESHOT];
                irq_en  <= wdata[CTRL_IRQ_EN];
                if (wdata[CTRL_EN] && !en) count <= reload;
            end
            if (terminal) begin
                if (oneshot) begin
                    count <= '0;
                    en    <= 1'b0;
                end else begin
                    count <= reload;
                end
            end else if (tick && count != '0) begin
                count <= count - WIDTH'(1);
            end
            // A clearing read that lands on a terminal keeps done but drops overrun.
            if (rd_status) begin
                done    <= terminal;
                overrun <= 1'b0;
            end else begin
                done <= done | terminal;
                if (terminal && done) overrun <= 1'b1;
            end
        end
    end

    assign irq = done & irq_en;

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:   rdata = {12'd0, irq_en, oneshot, mode, en};
            REG_RELOAD: rdata = 16'(reload);
            REG_COUNT:  rdata = 16'(count);
            REG_STATUS: rdata = {14'd0, overrun, done};
            default:    rdata = '0;
        endcase
    end
endmodule

// File: rtl/ctc_multi.sv
// rtl/ctc_multi.sv - N-channel counter/timer: address decode, read mux and irq merge
// Build option: CTC_PULSE_SYNC_EN (see ctc_channel).
`timescale 1ns/1ps
module ctc_multi
    import ctc_multi_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16
) (
    input  logic                clock,
    input  logic                reset,
    ctc_multi_if.slave          bus,
    input  logic [CHANNELS-1:0] pulse_in,
    output logic [CHANNELS-1:0] pulse_out,
    output logic                irq
);
    logic [15:0]         ch_rdata [CHANNELS];
    logic [CHANNELS-1:0] ch_irq;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ctc_channel #(.WIDTH(WIDTH)) u_ch (
            .clock     (clock),
            .reset     (reset),
            .sel       (bus.cs && (bus.addr[3:2] == 2'(i))),
            .iow       (bus.iow),
            .ior       (bus.ior),
            .reg_idx   (reg_e'(bus.addr[1:0])),
            .wdata     (bus.iowrite_data),
            .pulse_in  (pulse_in[i]),
            .rdata     (ch_rdata[i]),
            .pulse_out (pulse_out[i]),
            .irq       (ch_irq[i])
        );
    end

    // Unpopulated channel slots fall through to zero.
    always_comb begin
        bus.ioread_data = '0;
        if (bus.cs && bus.ior) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.addr[3:2] == 2'(i)) bus.ioread_data = ch_rdata[i];
            end
        end
    end

    assign irq = |ch_irq;
endmodule

// File: tb/tb_ctc_multi.sv
// tb/tb_ctc_multi.sv - directed self-checking bench for ctc_multi (2 channels, 12-bit)
`timescale 1ns/1ps
module tb_ctc_multi;
    logic       clock;
    logic       reset;
    logic [1:0] pulse_in;
    logic [1:0] pulse_out;
    logic       irq;
    int         checks;
    int         errors;

    ctc_multi_if bus ();

    ctc_multi #(.CHANNELS(2), .WIDTH(12)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .pulse_in  (pulse_in),
        .pulse_out (pulse_out),
        .irq       (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.cs = 1'b1; bus.iow = 1'b1; bus.addr = a; bus.iowrite_data = d;
        @(negedge clock);
        bus.cs = 1'b0; bus.iow = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        bus.cs = 1'b1; bus.ior = 1'b1; bus.addr = a;
        #1 d = bus.ioread_data;
        @(negedge clock);
        bus.cs = 1'b0; bus.ior = 1'b0;
    endtask

    task automatic pulse1(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_in[1] = 1'b1;
            @(negedge clock);
            pulse_in[1] = 1'b0;
            @(negedge clock);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic watch_count(input string tag, input logic [3:0] a,
                               input logic [15:0] exp[], input int pulse_at[]);
        bus.cs = 1'b1; bus.ior = 1'b1; bus.addr = a;
        for (int k = 0; k < exp.size(); k++) begin
            logic want_pulse;
            want_pulse = 1'b0;
            foreach (pulse_at[j]) if (pulse_at[j] == k) want_pulse = 1'b1;
            #1;
            check($sformatf("%s_count[%0d]", tag, k), bus.ioread_data, exp[k]);
            check($sformatf("%s_pulse[%0d]", tag, k), {15'd0, pulse_out[0]}, {15'd0, want_pulse});
            @(negedge clock);
        end
        bus.cs = 1'b0; bus.ior = 1'b0;
    endtask

    logic [15:0] d;
    int          npulse;

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; pulse_in = 2'b00;
        bus.cs = 1'b0; bus.iow = 1'b0; bus.ior = 1'b0; bus.addr = 4'h0; bus.iowrite_data = 16'h0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int a = 0; a < 8; a++) begin
            rd(4'(a), d);
            check($sformatf("reset_reg%0d", a), d, 16'h0);
        end
        check("reset_irq", {15'd0, irq}, 16'h0);
        check("reset_pulse_out", {14'd0, pulse_out}, 16'h0);

        wr(4'h1, 16'd5);
        wr(4'h0, 16'h0001);
        watch_count("periodic5", 4'h2,
                    '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd5},
                    '{5, 10});
        check("no_irq_without_en", {15'd0, irq}, 16'h0);
        wr(4'h0, 16'h0000);
        repeat (2) @(negedge clock);
        rd(4'h2, d);  check("frozen_count", d, 16'd4);
        rd(4'h3, d);  check("periodic_status", d, 16'h3);
        rd(4'h3, d);  check("periodic_status_cleared", d, 16'h0);

        wr(4'h5, 16'hFFFF);
        rd(4'h5, d);  check("reload_truncated", d, 16'h0FFF);
        wr(4'h9, 16'h1234);
        rd(4'h9, d);  check("ch2_reload_absent", d, 16'h0);
        rd(4'h8, d);  check("ch2_ctrl_absent", d, 16'h0);
        rd(4'h1, d);  check("ch0_reload_untouched", d, 16'd5);

        wr(4'h5, 16'd3);
        wr(4'h4, 16'h000B);
        pulse1(2);
        rd(4'h6, d);  check("counter_after_2", d, 16'd1);
        check("irq_before_terminal", {15'd0, irq}, 16'h0);
        pulse1(1);
        check("irq_after_terminal", {15'd0, irq}, 16'h1);
        rd(4'h7, d);  check("counter_status", d, 16'h1);
        check("irq_after_clear", {15'd0, irq}, 16'h0);
        rd(4'h7, d);  check("counter_status_cleared", d, 16'h0);
        rd(4'h6, d);  check("counter_reloaded", d, 16'd3);

        wr(4'h1, 16'd4);
        wr(4'h0, 16'h0005);
        watch_count("oneshot4", 4'h2,
                    '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0}, '{4});
        rd(4'h0, d);  check("oneshot_ctrl", d, 16'h4);
        rd(4'h3, d);  check("oneshot_status", d, 16'h1);

        wr(4'h1, 16'd2);
        wr(4'h0, 16'h0001);
        repeat (6) @(negedge clock);
        rd(4'h3, d);  check("overrun_status", d, 16'h3);
        rd(4'h3, d);  check("status_before_terminal_read", d, 16'h0);
        rd(4'h3, d);  check("status_after_terminal_read", d, 16'h1);
        wr(4'h0, 16'h0000);

        pulse1(3);
        check("irq_before_reset", {15'd0, irq}, 16'h1);
        wr(4'h1, 16'd10);
        wr(4'h0, 16'h0001);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("irq_after_reset", {15'd0, irq}, 16'h0);
        for (int a = 0; a < 8; a++) begin
            rd(4'(a), d);
            check($sformatf("midreset_reg%0d", a), d, 16'h0);
        end
        npulse = 0;
        repeat (20) begin
            @(negedge clock);
            if (pulse_out != 2'b00) npulse++;
        end
        check("no_pulse_after_reset", 16'(npulse), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctc_multi.md
# ctc_multi

Parametrised N-channel down-counter/timer peripheral on the Minisys 16-bit IO bus, generalising the single counter/timer (CTC) unit to configurable channel count and counter width. Each channel runs as a periodic or one-shot timer clocked by the system clock, or as an event counter driven by an external pulse pin. It raises a level interrupt toward the CPU's interrupt inputs (int0/int1 path) and returns register contents on the 16-bit IO read mux alongside the keyboard and UART units.

## Interface
- CHANNELS, 2, number of independent channels (1..4)
- WIDTH, 16, counter/reload width in bits (1..16); upper bus bits read as 0
- clock  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-low; sampled on clock rising edge
- cs  in  1  chip select from IO address decode
- iow  in  1  IO write strobe, qualified by cs
- ior  in  1  IO read strobe, qualified by cs
- addr  in  4  word index: channel = addr[3:2], register = addr[1:0]
- iowrite_data  in  16  write data
- ioread_data  out  16  read data, combinational; 0 when not (cs & ior)
- pulse_in  in  CHANNELS  external event inputs (counter mode)
- pulse_out  out  CHANNELS  one-cycle terminal-count pulse per channel
- irq  out  1  OR over channels of (done & irq_en)

## Operation
- Per-channel registers: 0 CTRL (rw: bit0 en, bit1 mode 0=timer/1=counter, bit2 oneshot, bit3 irq_en); 1 RELOAD (rw); 2 COUNT (ro); 3 STATUS (ro, read-clear: bit0 done, bit1 overrun).
- Access to channel index >= CHANNELS: writes ignored, reads return 0.
- Tick: timer mode = every cycle while en; counter mode = detected rising edge of pulse_in[i] while en.
- CTRL write with en 0->1: COUNT <= RELOAD next edge; no tick that cycle. en 1->1: no reload. en 1->0: COUNT frozen.
- On tick: COUNT decrements. If COUNT == 1: terminal — done <= 1, pulse_out[i] high one cycle, COUNT <= RELOAD (periodic) or COUNT <= 0 and en <= 0 (oneshot).
- Terminal while done already 1: overrun <= 1.
- RELOAD == 0 on enable: COUNT = 0, ticks ignored, never terminates.
- RELOAD write while running: no effect on COUNT until next reload.
- STATUS read (cs & ior, reg 3) clears done and overrun on that edge; simultaneous terminal: done stays 1, overrun not set by this event.
- Values written are truncated to WIDTH bits.

## Timing
- Reset: all CTRL/RELOAD/COUNT/STATUS = 0, pulse_out = 0, irq = 0, edge/sync flops = 0.
- Register writes take effect on the clock edge with cs & iow.
- Timer period = RELOAD cycles between pulse_out assertions.
- irq rises the cycle after terminal edge (registered done), falls the cycle after clearing read.
- Reset mid-count: all state zero next edge, no pulse_out.

## Configuration
- CTC_PULSE_SYNC_EN defined: pulse_in passes a 2-flop synchroniser then edge detector; COUNT changes on the 3rd rising edge after pulse_in first sampled high.
- Undefined: pulse_in assumed synchronous, edge detector only; COUNT changes on the 1st rising edge sampling pulse_in high after a low sample.

## Structure
- Shared package: register index constants (CTRL/RELOAD/COUNT/STATUS), CTRL bit positions, STATUS bit positions.
- One sub-module ctc_channel (one counter, its registers, edge detect/sync), instantiated CHANNELS times by generate; top holds address decode, read mux, irq OR.

## Test plan
- Ch0 RELOAD=5, CTRL=0x1 (periodic timer) -> pulse_out[0] every 5 cycles, COUNT reads 5,4,3,2,1,5...
- Ch1 RELOAD=3, CTRL=0xB (counter, irq_en) then 3 pulses on pulse_in[1] -> done=1, irq=1; STATUS read returns 0x1, then 0x0, irq drops.
- Ch0 RELOAD=4, CTRL=0x5 (oneshot) -> single pulse_out after 4 cycles, COUNT=0, CTRL reads 0x4.
- Periodic RELOAD=2, no STATUS read for 6 cycles -> STATUS reads 0x3 (done+overrun).
- STATUS read on exact terminal cycle -> done remains 1, overrun 0.
- reset=0 mid-count with RELOAD=10 -> all reads 0, irq=0, no pulse_out thereafter.
